// File: rtl/avalon_sdram_arbiter_if.sv
// Avalon-MM bus bundle shared by both requesters and the SDRAM side.
// "master" drives commands; "slave" answers with stall and read returns.
// Handshake: a command (read or write) is accepted on a clock edge where it
// is presented and waitrequest is 0; readdatavalid marks one read beat.
interface avalon_sdram_arbiter_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 32
);
    logic [ADDR_W-1:0]       address;
    logic                    read;
    logic                    write;
    logic [8*DATA_BYTES-1:0] writedata;
    logic [DATA_BYTES-1:0]   byteenable;
    logic                    waitrequest;
    logic [8*DATA_BYTES-1:0] readdata;
    logic                    readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_sdram_arbiter.sv
// Two-requester arbiter for the single SDRAM Avalon port. Port 0 is the
// display fetch (reads), port 1 the host/stream writes. Grants are bounded
// by BURST_MAX accepted transfers; a tag FIFO remembers which port issued
// each pipelined read so returns are routed back to the right requester.
module avalon_sdram_arbiter #(
    parameter int DATA_BYTES  = 4,
    parameter int ADDR_W      = 32,
    parameter int MAX_PENDING = 8,
    parameter int BURST_MAX   = 16,
    parameter int PRIO0       = 1
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    avalon_sdram_arbiter_if.slave       s0,
    avalon_sdram_arbiter_if.slave       s1,
    avalon_sdram_arbiter_if.master      m,
    output logic                        err_orphan,
    output logic [1:0]                  fsm_state
);
    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int PTR_W  = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W  = $clog2(BURST_MAX + 1);

    // Encoding is visible on fsm_state: 0 idle, 1 port 0 granted, 2 port 1.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic             last_grant;

    logic             tags [MAX_PENDING];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    logic fifo_full, fifo_empty, head;
    logic sel_read, sel_write, cmd_read, accepted, release_grant;
    logic push, pop, grant_port;
    logic req0, req1;

    assign fifo_full  = (count == (PTR_W+1)'(MAX_PENDING));
    assign fifo_empty = (count == '0);
    assign head       = tags[rd_ptr];
    assign grant_port = (state == GRANT1);
    assign req0       = s0.read | s0.write;
    assign req1       = s1.read | s1.write;
    assign fsm_state  = state;

    // Read returns: data fans out to both ports, the valid follows the FIFO head.
    assign s0.readdata      = m.readdata;
    assign s1.readdata      = m.readdata;
    assign pop              = m.readdatavalid & ~fifo_empty;
    assign s0.readdatavalid = pop & (head == 1'b0);
    assign s1.readdatavalid = pop & (head == 1'b1);

    // Command mux, stall generation, arbitration and grant release.
    always_comb begin
        state_next     = state;
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        m.address      = ADDR_W'(0);
        m.writedata    = DATA_W'(0);
        m.byteenable   = DATA_BYTES'(0);
        s0.waitrequest = 1'b1;
        s1.waitrequest = 1'b1;

        case (state)
            GRANT0: begin
                m.address      = s0.address;
                m.writedata    = s0.writedata;
                m.byteenable   = s0.byteenable;
                sel_read       = s0.read;
                sel_write      = s0.write;
                // A read is held off while there is no room for its tag.
                s0.waitrequest = m.waitrequest | (s0.read & fifo_full);
            end
            GRANT1: begin
                m.address      = s1.address;
                m.writedata    = s1.writedata;
                m.byteenable   = s1.byteenable;
                sel_read       = s1.read;
                sel_write      = s1.write;
                s1.waitrequest = m.waitrequest | (s1.read & fifo_full);
            end
            default: begin
                // Round-robin favours the port not granted last; PRIO0 lets port 0 always win.
                if (req0 && ((PRIO0 != 0) || !req1 || last_grant))
                    state_next = GRANT0;
                else if (req1)
                    state_next = GRANT1;
            end
        endcase

        cmd_read      = sel_read & ~fifo_full;
        m.read        = cmd_read;
        m.write       = sel_write;
        accepted      = (cmd_read | sel_write) & ~m.waitrequest;
        push          = cmd_read & ~m.waitrequest;
        release_grant = (state != IDLE) &&
                        (!(sel_read || sel_write) ||
                         (accepted && beat_cnt == CNT_W'(BURST_MAX - 1)));
        if (release_grant)
            state_next = IDLE;
    end

    // State, burst budget, fairness memory, FIFO pointers and orphan flag.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            state <= state_next;
            if (release_grant) begin
                beat_cnt   <= '0;
                last_grant <= grant_port;
            end else if (accepted) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (m.readdatavalid && fifo_empty)
                err_orphan <= 1'b1;
        end
    end

    // Tag storage: contents are only meaningful between the pointers.
    always_ff @(posedge sys_clk) begin
        if (push)
            tags[wr_ptr] <= grant_port;
    end
endmodule

// File: tb/tb_avalon_sdram_arbiter.sv
// Directed bench for avalon_sdram_arbiter: reset behaviour, fixed-priority
// and round-robin burst grants, pipelined read routing, tag FIFO full and
// orphan returns. Inputs change 1ns after the rising edge, checks happen on
// the falling edge.
module tb_avalon_sdram_arbiter;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic err_orphan, r_err_orphan;
    logic [1:0] fsm_state, r_fsm_state;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) s0_if ();
    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) s1_if ();
    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) m_if ();
    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) r_s0_if ();
    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) r_s1_if ();
    avalon_sdram_arbiter_if #(.DATA_BYTES(4), .ADDR_W(32)) r_m_if ();

    avalon_sdram_arbiter #(.PRIO0(1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s0(s0_if), .s1(s1_if), .m(m_if),
        .err_orphan(err_orphan), .fsm_state(fsm_state)
    );

    avalon_sdram_arbiter #(.PRIO0(0)) dut_rr (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s0(r_s0_if), .s1(r_s1_if), .m(r_m_if),
        .err_orphan(r_err_orphan), .fsm_state(r_fsm_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s0_if.address = '0; s0_if.read = 0; s0_if.write = 0; s0_if.writedata = '0; s0_if.byteenable = 4'hF;
        s1_if.address = '0; s1_if.read = 0; s1_if.write = 0; s1_if.writedata = '0; s1_if.byteenable = 4'hF;
        m_if.waitrequest = 0; m_if.readdata = '0; m_if.readdatavalid = 0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int s1_busy;
        logic [31:0] exp_data;
        logic [1:0]  exp_state;
        logic        exp0, exp1;

        r_s0_if.address = '0; r_s0_if.read = 0; r_s0_if.write = 0; r_s0_if.writedata = '0; r_s0_if.byteenable = 4'hF;
        r_s1_if.address = '0; r_s1_if.read = 0; r_s1_if.write = 0; r_s1_if.writedata = '0; r_s1_if.byteenable = 4'hF;
        r_m_if.waitrequest = 0; r_m_if.readdata = '0; r_m_if.readdatavalid = 0;

        // Reset held with port 0 requesting; first command two cycles after release.
        clear_inputs();
        s0_if.read = 1; s0_if.address = 32'h40; m_if.waitrequest = 1;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_m_read", m_if.read, 0);
        check("rst_s0_wait", s0_if.waitrequest, 1);
        check("rst_s1_wait", s1_if.waitrequest, 1);
        check("rst_rdv", {s0_if.readdatavalid, s1_if.readdatavalid}, 0);
        check("rst_err", err_orphan, 0);
        check("rst_state", fsm_state, 0);
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("lat_idle_m_read", m_if.read, 0);
        check("lat_idle_state", fsm_state, 0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        check("lat_m_read", m_if.read, 1);
        check("lat_m_addr", m_if.address, 32'h40);
        check("lat_state", fsm_state, 1);
        check("lat_s0_wait_follows", s0_if.waitrequest, 1);
        check("lat_s1_wait", s1_if.waitrequest, 1);
        @(posedge sys_clk); #1 m_if.waitrequest = 0;
        @(negedge sys_clk);
        check("lat_s0_wait_low", s0_if.waitrequest, 0);

        // Fixed priority: both ports write forever, port 0 keeps the bus.
        clear_inputs();
        s0_if.write = 1; s0_if.writedata = 32'hAAAA0000;
        s1_if.write = 1; s1_if.writedata = 32'hBBBB0000;
        do_reset();
        @(negedge sys_clk);
        check("prio_first_idle", fsm_state, 0);
        cnt = 0; s1_busy = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk);
            if (fsm_state == 2'd1 && m_if.write && m_if.writedata == 32'hAAAA0000) cnt++;
            if (!s1_if.waitrequest) s1_busy++;
        end
        check("prio_burst_len", cnt, 16);
        @(negedge sys_clk);
        check("prio_bubble", {fsm_state, m_if.write}, {2'd0, 1'b0});
        if (!s1_if.waitrequest) s1_busy++;
        @(negedge sys_clk);
        check("prio_regrant0", fsm_state, 1);
        check("prio_s1_never", s1_busy, 0);

        // Round-robin: port 0 first, then both request; grants alternate.
        r_s0_if.write = 1; r_s0_if.writedata = 32'h00000A0A;
        r_s1_if.writedata = 32'h00000B0B;
        do_reset();
        @(posedge sys_clk); #1 r_s1_if.write = 1;
        for (int p = 0; p < 4; p++) begin
            exp_state = (p % 2 == 1) ? 2'd2 : 2'd1;
            exp_data  = (p % 2 == 1) ? 32'h00000B0B : 32'h00000A0A;
            cnt = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge sys_clk);
                if (r_fsm_state == exp_state && r_m_if.write && r_m_if.writedata == exp_data) cnt++;
            end
            check($sformatf("rr_burst%0d", p), cnt, 16);
            @(negedge sys_clk);
            check($sformatf("rr_bubble%0d", p), {r_fsm_state, r_m_if.write}, {2'd0, 1'b0});
        end
        r_s0_if.write = 0; r_s1_if.write = 0;

        // Pipelined reads, 5-cycle return latency: s0 x3 then s1 x2.
        clear_inputs();
        s0_if.read = 1; s0_if.address = 32'h100; s1_if.address = 32'h200;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            @(posedge sys_clk); #1;
            m_if.readdatavalid = (c == 7 || c == 8 || c == 9 || c == 12 || c == 13);
            m_if.readdata = 32'hD0000000 + 32'(c);
            if (c == 4) begin s0_if.read = 0; s1_if.read = 1; end
            if (c == 8) s1_if.read = 0;
            @(negedge sys_clk);
            if (c == 1) begin
                check("pipe_m_read", m_if.read, 1);
                check("pipe_m_addr0", m_if.address, 32'h100);
            end
            if (c == 5) check("pipe_bubble", m_if.read, 0);
            if (c == 6) begin
                check("pipe_m_addr1", m_if.address, 32'h200);
                check("pipe_state1", fsm_state, 2);
                check("pipe_s0_wait", s0_if.waitrequest, 1);
            end
            exp0 = (c == 7 || c == 8 || c == 9);
            exp1 = (c == 12 || c == 13);
            check($sformatf("pipe_rdv0_c%0d", c), s0_if.readdatavalid, exp0);
            check($sformatf("pipe_rdv1_c%0d", c), s1_if.readdatavalid, exp1);
            if (exp0) check($sformatf("pipe_data0_c%0d", c), s0_if.readdata, 32'hD0000000 + 32'(c));
            if (exp1) check($sformatf("pipe_data1_c%0d", c), s1_if.readdata, 32'hD0000000 + 32'(c));
        end
        check("pipe_no_orphan", err_orphan, 0);

        // Tag FIFO full: 8 reads fill it, 9th held, write passes, one return frees a slot.
        clear_inputs();
        s0_if.read = 1; s0_if.address = 32'h300;
        do_reset();
        cnt = 0;
        for (int c = 1; c <= 13; c++) begin
            @(posedge sys_clk); #1;
            if (c == 10) begin s0_if.read = 0; s0_if.write = 1; s0_if.writedata = 32'hCAFE; end
            if (c == 11) begin s0_if.read = 1; s0_if.write = 0; m_if.readdatavalid = 1; m_if.readdata = 32'h1111; end
            if (c == 12) m_if.readdatavalid = 0;
            @(negedge sys_clk);
            if (c <= 8 && m_if.read && !s0_if.waitrequest) cnt++;
            if (c == 9) begin
                check("full_8_reads", cnt, 8);
                check("full_m_read", m_if.read, 0);
                check("full_s0_wait", s0_if.waitrequest, 1);
                check("full_state", fsm_state, 1);
            end
            if (c == 10) begin
                check("full_write", m_if.write, 1);
                check("full_write_wait", s0_if.waitrequest, 0);
                check("full_write_data", m_if.writedata, 32'hCAFE);
            end
            if (c == 11) begin
                check("full_hold_m_read", m_if.read, 0);
                check("full_hold_wait", s0_if.waitrequest, 1);
                check("full_return", s0_if.readdatavalid, 1);
            end
            if (c == 12) begin
                check("freed_m_read", m_if.read, 1);
                check("freed_wait", s0_if.waitrequest, 0);
            end
            if (c == 13) check("refull_m_read", m_if.read, 0);
        end

        // Reset discards the in-flight tags, so the next return is an orphan.
        clear_inputs();
        do_reset();
        @(posedge sys_clk); #1 m_if.readdatavalid = 1; m_if.readdata = 32'h55;
        @(negedge sys_clk);
        check("orph_rdv", {s0_if.readdatavalid, s1_if.readdatavalid}, 0);
        check("orph_err_pending", err_orphan, 0);
        @(posedge sys_clk); #1 m_if.readdatavalid = 0;
        @(negedge sys_clk);
        check("orph_err_set", err_orphan, 1);
        repeat (3) @(negedge sys_clk);
        check("orph_err_sticky", err_orphan, 1);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        check("orph_err_cleared", err_orphan, 0);
        sys_rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/avalon_sdram_arbiter.md
# avalon_sdram_arbiter

Shares the single Avalon SDRAM master port of the video controller between two Avalon requesters: port 0 is the video read path (display fetch), port 1 is the host/stream write path. It grants the port to one requester at a time, bounds each grant by a transfer budget, and tracks outstanding pipelined reads so each `readdatavalid` beat returns to the requester that issued it. It sits between the requesters and `avalon_if_sdram`, in the `sys_clk` domain.

## Interface
- `DATA_BYTES`, default 4: data bus width in bytes; data width is 8*DATA_BYTES.
- `ADDR_W`, default 32: address width.
- `MAX_PENDING`, default 8 (power of 2): depth of the outstanding-read tag FIFO.
- `BURST_MAX`, default 16: maximum accepted transfers per grant.
- `PRIO0`, default 1: 1 = port 0 wins every arbitration; 0 = round-robin.
- `sys_clk`  in  1  system clock, 100 MHz.
- `sys_rst`  in  1  reset; synchronous, active-high.
- `sN_address`  in  ADDR_W  requester N address (N = 0, 1).
- `sN_read`, `sN_write`  in  1  requester N commands.
- `sN_writedata`  in  8*DATA_BYTES  requester N write data.
- `sN_byteenable`  in  DATA_BYTES  requester N byte enables.
- `sN_waitrequest`  out  1  stall to requester N.
- `sN_readdata`  out  8*DATA_BYTES  read data to requester N.
- `sN_readdatavalid`  out  1  read beat for requester N.
- `m_address`, `m_read`, `m_write`, `m_writedata`, `m_byteenable`  out  as above  commands to SDRAM.
- `m_waitrequest`  in  1  SDRAM stall.
- `m_readdata`  in  8*DATA_BYTES; `m_readdatavalid`  in  1  SDRAM read returns.
- `err_orphan`  out  1  sticky: a read beat arrived with no pending tag.

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE: `m_read` = `m_write` = 0; both `sN_waitrequest` = 1. If any `sN_read|sN_write`, pick the winner and register the grant. With PRIO0=1, port 0 wins whenever it requests. With PRIO0=0, a simultaneous request goes to the port not granted last; after reset, port 0 is treated as last granted.
- GRANTn: the `m_*` command signals are the port-n inputs, passed through combinationally. `sn_waitrequest` = `m_waitrequest`, except as noted below. The other port's waitrequest = 1.
- Accepted transfer: `m_read|m_write` while `m_waitrequest` = 0. Each accepted transfer increments `beat_cnt`.
- Release to IDLE at the first clock edge where either:
  - no command is presented by port n, or
  - a transfer is accepted with `beat_cnt` = BURST_MAX-1.
- On release, `beat_cnt` clears and last-granted is updated.
- Read tags: every accepted read pushes n into the tag FIFO.
  - If the FIFO is full, a read from the granted port is held: `m_read` = 0 and `sn_waitrequest` = 1.
  - Writes pass regardless of FIFO occupancy.
  - Full blocks the push even if a pop occurs in the same cycle.
- Returns: `sN_readdata` = `m_readdata` on both ports. `sN_readdatavalid` = `m_readdatavalid` & FIFO non-empty & head = N. Each such beat pops the head.
- A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- `m_readdatavalid` with an empty FIFO: the beat is dropped, no `sN_readdatavalid` is asserted, and `err_orphan` is set. `err_orphan` clears only on reset.
- Reset values: state IDLE, FIFO empty, `beat_cnt` 0, `err_orphan` 0. Outputs are `m_read`/`m_write` 0, both `sN_waitrequest` 1, both `sN_readdatavalid` 0.
- Reset mid-operation: in-flight tags are discarded. Returns arriving after reset are orphans.

## Timing
- Request-to-command latency: 1 cycle. A request seen in IDLE at edge k appears on `m_*` in cycle k+1.
- Re-arbitration bubble: 1 IDLE cycle after every release.
- Readdata path: 0 cycles; routing is combinational from the registered FIFO head.
- Sustained throughput within a grant: 1 transfer per cycle while `m_waitrequest` = 0.

## Test plan
- Reset with `s0_read` = 1: `m_read` = 0 and `s0_waitrequest` = 1 while `sys_rst` = 1. The first `m_read` appears 2 cycles after `sys_rst` falls (IDLE registers the grant, then the command goes out).
- PRIO0=1, both ports request continuously: port 0 issues 16 accepted transfers, then 1 IDLE cycle, then port 0 is granted again. Port 1 is not granted while port 0 keeps requesting.
- PRIO0=0, both ports request continuously: grants alternate 0,1,0,1, with 16 transfers each, separated by 1 IDLE cycle.
- Pipelined reads with a 5-cycle SDRAM latency:
  - port 0 issues 3 reads, then port 1 issues 2 reads;
  - the 5 returns route in order as `s0` ×3 then `s1` ×2;
  - `readdata` values match `m_readdata` per beat.
- Tag FIFO full: hold returns while port 0 issues reads. The 9th read sees `s0_waitrequest` = 1 and `m_read` = 0. A write issued from port 0 while the FIFO is full is still accepted. Releasing one return lets the held read be accepted the following cycle.
- Orphan return: pulse `m_readdatavalid` with the FIFO empty. No `sN_readdatavalid` is asserted, `err_orphan` = 1 and stays 1 until `sys_rst`.
